// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first,
// one bit per clock, and publishes sum/cout on a single completion edge.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-high reset
//   start - begin an addition (accepted only in IDLE)
//   a, b  - WIDTH-bit operands, captured on the accept edge
//   cin   - carry-in, captured on the accept edge
//   busy  - high while bits are being processed (RUN)
//   done  - one-cycle completion pulse (DONE)
//   sum   - registered result, changes only on completion or reset
//   cout  - registered carry-out, changes only on completion or reset

// 1-bit full adder built from 2:1 selections.
// Ports: a_i, b_i, c_i operand/carry bits; s_o sum; co_o carry.
module full_adder_mux (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    logic p;

    assign p    = a_i ^ b_i;
    // Propagate: sum is inverted carry, carry passes through.
    // Otherwise a_i == b_i and either one is the generated carry.
    assign s_o  = c_i ? ~p : p;
    assign co_o = p ? c_i : a_i;

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] ps_next;

    full_adder_mux u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (c_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
    assign ps_next = {fa_s, ps_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ps_d  = ps_next;
                c_d   = fa_co;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = ps_next;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks for serial_adder_ctrl at WIDTH=8.
// Expected results come from integer addition done in the bench.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_chk;
    int n_err;
    int overlap;

    logic [W-1:0] m_sum;
    logic         m_cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done && busy) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one addition from IDLE and check timing and result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc);
        logic [W:0] exp;
        int k;
        int busy_n;
        exp = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        a = ta;
        b = tb;
        cin = tc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta;
        b = ~tb;
        cin = ~tc;
        k = 0;
        busy_n = 0;
        while (!done && k < 40) begin
            if (busy) busy_n++;
            if (k == 4) begin
                check("hold_sum", sum, m_sum);
                check("hold_cout", cout, m_cout);
            end
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, W);
        check("busy_cycles", busy_n, W);
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
        @(posedge clk);
        #1;
        check("done_width", done, 0);
        m_sum = exp[W-1:0];
        m_cout = exp[W];
    endtask

    initial begin
        int last;
        int nd;
        int nd_after;
        n_chk = 0;
        n_err = 0;
        overlap = 0;
        m_sum = '0;
        m_cout = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;

        // Reset wins over start.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);

        // First edge with rst low accepts the held start.
        rst = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("first_accept", busy, 1);
        repeat (W + 1) @(posedge clk);
        #1;
        check("first_done", done, 0);

        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h12, 8'h34, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1);
        run_op(8'h80, 8'h80, 1'b1);
        run_op(8'h7F, 8'h00, 1'b1);

        // Start held high: one result every W+2 cycles.
        a = 8'h03;
        b = 8'h04;
        cin = 1'b0;
        start = 1'b1;
        last = 0;
        nd = 0;
        for (int e = 1; e <= 80 && nd < 4; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check("b2b_sum", sum, 8'h07);
                check("b2b_cout", cout, 0);
                if (nd > 0) check("b2b_period", e - last, W + 2);
                last = e;
                nd++;
                a = 8'h03;
                b = 8'h04;
                cin = 1'b0;
            end else if (busy) begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
            end
        end
        start = 1'b0;
        check("b2b_count", nd, 4);
        repeat (2) @(posedge clk);
        #1;
        m_sum = 8'h07;
        m_cout = 1'b0;

        // Reset in the 4th RUN cycle abandons the addition.
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        nd_after = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) nd_after++;
        end
        check("abort_no_done", nd_after, 0);
        m_sum = '0;
        m_cout = 1'b0;
        run_op(8'hC3, 8'h3D, 1'b0);

        // Random sweep.
        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        check("done_busy_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
